// File: rtl/otp_stream_xor.sv
// otp_stream_xor: byte-stream one-time-pad cipher stage.
// Drives the pad generator's load/shift controls, XORs each accepted byte
// bit-serially (LSB first) with the generator's serial output and returns
// the result on a valid/ready handshake. Encrypt and decrypt are identical.
module otp_stream_xor #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        key,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ks_load,
  output logic              ks_sh,
  input  logic              ks_bit,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  byte_cnt
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_READY,
    S_SHIFT,
    S_HOLD
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   in_buf_q, in_buf_d;
  logic [DATA_W-1:0]   out_buf_q, out_buf_d;
  logic [BIT_W-1:0]    bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;

  // The key only feeds the external generator; it is not consumed here.
  logic unused_key;
  assign unused_key = ^key;

  // Next-state and datapath update for the load / accept / shift / hold cycle.
  always_comb begin
    state_d    = state_q;
    in_buf_d   = in_buf_q;
    out_buf_d  = out_buf_q;
    bit_idx_d  = bit_idx_q;
    byte_cnt_d = byte_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        byte_cnt_d = '0;
        state_d    = S_READY;
      end
      S_READY: begin
        // start wins over in_valid so a reload never swallows a byte
        if (start) begin
          state_d = S_LOAD;
        end else if (in_valid) begin
          in_buf_d  = in_data;
          bit_idx_d = '0;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        out_buf_d[bit_idx_q] = in_buf_q[bit_idx_q] ^ ks_bit;
        bit_idx_d            = bit_idx_q + 1'b1;
        if (bit_idx_q == LAST_BIT) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = S_READY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_buf_q   <= '0;
      out_buf_q  <= '0;
      bit_idx_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_buf_q   <= in_buf_d;
      out_buf_q  <= out_buf_d;
      bit_idx_q  <= bit_idx_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // Outputs are state decodes, except in_ready which also masks on start.
  assign in_ready  = (state_q == S_READY) && !start;
  assign ks_load   = (state_q == S_LOAD);
  assign ks_sh     = (state_q == S_SHIFT);
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign out_data  = out_buf_q;
  assign byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_otp_stream_xor.sv
// Bench for otp_stream_xor with an attached model of the 8-bit pad shift
// register. Expected ciphertext comes from keystream position arithmetic.
module tb_otp_stream_xor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  key = 8'h00;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        ks_load;
  logic        ks_sh;
  logic        ks_bit;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [15:0] byte_cnt;

  logic [7:0]  gen;
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [7:0] key;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  otp_stream_xor #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ks_load(ks_load), .ks_sh(ks_sh), .ks_bit(ks_bit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  // Pad generator: load captures key, shift rotates right, output is bit 0.
  always @(posedge clk) begin
    if (ks_load)    gen <= key;
    else if (ks_sh) gen <= {gen[0], gen[7:1]};
  end
  assign ks_bit = gen[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Byte n after a load is XORed with keystream bits 8n..8n+7; the generator
  // repeats the key every 8 bits, so stream bit k is key[k mod 8].
  function automatic logic [7:0] ref_byte(input logic [7:0] k, input int n, input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[i] ^ k[(8 * n + i) % 8];
    return r;
  endfunction

  // Called at a negedge in READY; returns at the negedge in READY after load.
  task automatic do_start(input logic [7:0] k);
    key = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("load_pulse", ks_load, 1);
    check("load_in_ready", in_ready, 0);
    @(negedge clk);
    check("load_cnt_clr", byte_cnt, 0);
  endtask

  // Called at a negedge; holds out_ready low for 'hold' cycles of HOLD.
  task automatic send_byte(input logic [7:0] d, input int hold,
                           output logic [7:0] q, output int lat);
    int t;
    logic [7:0] g;
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) timeout("accept");
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(negedge clk); lat++; end
    if (lat >= 40) timeout("out_valid");
    q = out_data;
    g = gen;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_data", out_data, q);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_ks_sh", ks_sh, 0);
      check("hold_gen", gen, g);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    vec_t       tbl[6];
    string      s;
    logic [7:0] ct[36];
    logic [7:0] q;
    logic [7:0] k;
    logic [7:0] d;
    int         lat;
    int         t;

    tbl[0] = '{8'h2A, 8'h55, 8'h7F};
    tbl[1] = '{8'h2A, 8'h6E, 8'h44};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF};
    tbl[3] = '{8'h00, 8'hA5, 8'hA5};
    tbl[4] = '{8'h0F, 8'hF0, 8'hFF};
    tbl[5] = '{8'h81, 8'h81, 8'h00};
    s = "Universidade Federal de Minas Gerais";

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ks_load", ks_load, 0);
    check("rst_ks_sh", ks_sh, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    check("rst_byte_cnt", byte_cnt, 0);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);
    end
    in_valid = 1'b0;

    // Table vectors, each from a fresh load
    for (int i = 0; i < 6; i++) begin
      do_start(tbl[i].key);
      send_byte(tbl[i].din, 0, q, lat);
      check($sformatf("tbl%0d_out", i), q, tbl[i].exp);
      check($sformatf("tbl%0d_lat", i), lat, 8);
      check($sformatf("tbl%0d_cnt", i), byte_cnt, 1);
    end

    // Stream encryption with one backpressured byte
    do_start(8'h2A);
    for (int i = 0; i < 36; i++) begin
      send_byte(s[i], (i == 3) ? 5 : 0, q, lat);
      ct[i] = q;
      check($sformatf("enc%0d", i), q, ref_byte(8'h2A, i, s[i]));
    end
    check("enc_n_const", ct[1], 8'h44);
    check("enc_cnt", byte_cnt, 36);

    // Decryption restores plaintext
    do_start(8'h2A);
    for (int i = 0; i < 36; i++) begin
      send_byte(ct[i], 0, q, lat);
      check($sformatf("dec%0d", i), q, s[i]);
    end
    check("dec_cnt", byte_cnt, 36);

    // start and in_valid together in READY: start wins
    do_start(8'h2A);
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h3C;
    #1;
    check("prio_in_ready", in_ready, 0);
    @(negedge clk);
    start = 1'b0;
    check("prio_load", ks_load, 1);
    check("prio_load_in_ready", in_ready, 0);
    @(negedge clk);
    check("prio_ready", in_ready, 1);
    send_byte(8'h3C, 0, q, lat);
    check("prio_out", q, ref_byte(8'h2A, 0, 8'h3C));
    check("prio_cnt", byte_cnt, 1);

    // start during SHIFT is ignored
    in_data = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    key = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    check("shift_start_no_load", ks_load, 0);
    check("shift_start_still_sh", ks_sh, 1);
    start = 1'b0;
    key = 8'h2A;
    t = 0;
    while (!out_valid && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) timeout("shift_start_valid");
    check("shift_start_out", out_data, ref_byte(8'h2A, 1, 8'hC3));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("shift_start_cnt", byte_cnt, 2);

    // Reset after the third SHIFT edge
    in_data = 8'h99;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_sh_before", ks_sh, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ks_sh", ks_sh, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_cnt", byte_cnt, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_busy", busy, 0);
    end
    in_valid = 1'b0;

    // Random keys and bytes with random backpressure
    for (int r = 0; r < 3; r++) begin
      k = 8'($urandom);
      do_start(k);
      for (int n = 0; n < 12; n++) begin
        d = 8'($urandom);
        send_byte(d, $urandom_range(0, 2), q, lat);
        check($sformatf("rnd%0d_%0d", r, n), q, ref_byte(k, n, d));
        check("rnd_lat", lat, 8);
      end
      check("rnd_cnt", byte_cnt, 12);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/otp_stream_xor.md
# otp_stream_xor

Byte-stream cipher stage directly downstream of the 8-bit one-time-pad shift register (`ShiftRegister_8bit`). It accepts message bytes on a valid/ready handshake and drives the generator's `load`/`sh` controls. Each byte is XORed bit-serially with the generator's `serial_out`, LSB first, and the ciphered byte is presented on a second valid/ready handshake. The same block performs encryption and decryption: loading the same key and feeding it ciphertext restores the plaintext.

## Interface
- `DATA_W`, default 8: message byte width; the bit counter is sized to count 0..DATA_W-1.
- `CNT_W`, default 16: width of the processed-byte counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key`  in  8  pad value; connects to the generator's `data` input.
- `start`  in  1  single-cycle request to (re)load the pad and clear `byte_cnt`.
- `in_data`  in  DATA_W  message byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `ks_load`  out  1  connects to the generator's `load`.
- `ks_sh`  out  1  connects to the generator's `sh`; the generator advances one bit per cycle while this is high.
- `ks_bit`  in  1  current keystream bit; connects to the generator's `serial_out`.
- `out_data`  out  DATA_W  ciphered byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  downstream accepts `out_data`.
- `busy`  out  1  high in LOAD, SHIFT and HOLD.
- `byte_cnt`  out  CNT_W  bytes delivered since the last `start`.

## Operation
- The FSM has five states: IDLE, LOAD, READY, SHIFT and HOLD.
- IDLE: reset state; `in_ready`=0. `start` moves the FSM to LOAD.
- LOAD: lasts exactly 1 cycle with `ks_load`=1. `byte_cnt` clears to 0. The FSM then moves to READY.
- READY: `in_ready` = ~`start`.
  - `start`=1 goes to LOAD; `start` has priority over `in_valid`.
  - Otherwise, `in_valid`=1 captures `in_data` into `in_buf`, clears bit counter `bit_idx`, and goes to SHIFT.
- SHIFT: `ks_sh`=1 for exactly DATA_W cycles.
  - Each edge sets `out_buf[bit_idx]` <= `in_buf[bit_idx]` ^ `ks_bit` and increments `bit_idx`.
  - The edge that processes `bit_idx`=DATA_W-1 moves the FSM to HOLD.
- HOLD: `out_valid`=1 and `out_data`=`out_buf`, both stable until the handshake.
  - The `out_valid`&`out_ready` edge increments `byte_cnt`, which wraps from 2^CNT_W-1 to 0, and moves the FSM to READY.
- `start` is ignored in SHIFT and HOLD.
- `in_ready` is 0 in every state except READY.
- `ks_load` and `ks_sh` are never high in the same cycle.
- The keystream is never advanced outside SHIFT, so byte n always uses keystream bits 8n..8n+7 after the load.
- `out_data` drives `out_buf` at all times and equals 0 until the first byte completes.

## Timing
- Reset (`rst_n`=0, applied asynchronously): FSM enters IDLE.
  - All outputs go to 0: `in_ready`, `ks_load`, `ks_sh`, `out_valid`, `busy`, `out_data` and `byte_cnt`.
  - `in_buf`, `out_buf` and `bit_idx` clear.
- Reset mid-SHIFT or mid-HOLD: the partial byte is discarded and `ks_sh` drops immediately.
  - The generator has no reset, so its position is undefined; a new `start` is mandatory.
- Load latency: a `start` sampled at edge E0 gives `ks_load`=1 during the cycle after E0; READY is reached at edge E1.
- Byte latency: accept at edge A puts the FSM in SHIFT during cycles A+1..A+8 (for DATA_W=8), and `out_valid` rises after edge A+8.
- Throughput: with `in_valid` and `out_ready` held high, one byte is accepted every 10 cycles (8 SHIFT + 1 HOLD + 1 READY).
- `in_ready` is combinational in `start`; all other outputs are registered or decoded from state only.

## Test plan
- Bench model of the generator: 8-bit register, `load` captures `key`, `sh` rotates right, `serial_out`=reg[0].
- Encrypt: `key`=8'h2A, `start`, then `in_data`=8'h55 ('U') -> `out_data`=8'h7F, `out_valid` exactly 8 cycles after acceptance, `byte_cnt`=1.
- Stream and decrypt: 36 bytes "Universidade Federal de Minas Gerais" -> each output = byte ^ 8'h2A (e.g. 'n' 8'h6E -> 8'h44).
  - Re-`start` with `key`=8'h2A and feed the ciphertext -> the original 36 bytes return in order; `byte_cnt`=36.
- Backpressure: `out_ready`=0 for 5 cycles in HOLD -> `out_data` stable, `in_ready`=0, `ks_sh`=0, generator does not advance; the next byte still uses bits 8..15.
- Reset mid-operation: assert `rst_n`=0 after the 3rd SHIFT edge -> all outputs 0 immediately.
  - After release, `in_valid`=1 without `start` -> `in_ready` stays 0.
- Priority: `start`=1 and `in_valid`=1 in the same READY cycle -> `in_ready`=0, LOAD follows, and the byte is accepted on the next READY cycle.
  - `start` pulsed during SHIFT -> ignored; the byte completes unchanged.
